// File: rtl/serial_dac_drv.sv
// Serial DAC write engine: accepts NUM_CH parallel words and shifts them MSB-first with shared SCLK/CS/LD.
// Optional clear command enabled by defining SERIAL_DAC_DRV_CLR_CMD_EN (adds clr_req and the CLR state).
module serial_dac_drv #(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 1,
  parameter int CLK_DIV = 1,
  parameter int LD_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
  input  logic                     clr_req,
`endif
  output logic                     in_ready,
  output logic                     done,
  output logic                     dac_sclk,
  output logic [NUM_CH-1:0]        dac_sdi,
  output logic                     dac_cs_n,
  output logic                     dac_ld_n,
  output logic                     dac_clr_n
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int LDC_W = $clog2(LD_W + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
  localparam logic [LDC_W-1:0] LAST_LD  = LDC_W'(LD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    LD,
    CLR
  } state_t;

  state_t                         r_state, w_stateNxt;
  logic [DIV_W-1:0]               r_div, w_divNxt;
  logic [BIT_W-1:0]               r_bit, w_bitNxt;
  logic [LDC_W-1:0]               r_ldCnt, w_ldCntNxt;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_shift, w_shiftNxt;
  logic                           r_sclk, w_sclkNxt;
  logic [NUM_CH-1:0]              r_sdi, w_sdiNxt;
  logic                           r_csN, w_csNNxt;
  logic                           r_ldN, w_ldNNxt;
  logic                           r_clrN, w_clrNNxt;
  logic                           r_done, w_doneNxt;
  logic                           w_clrReq;
  logic                           w_clrGo;
  logic                           w_accept;

`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
  // A clear requested while busy waits here until the engine is back in IDLE.
  logic r_clrPend, w_clrPendNxt;
  assign w_clrReq     = clr_req | r_clrPend;
  assign w_clrPendNxt = (r_clrPend | clr_req) & ~w_clrGo;
`else
  assign w_clrReq = 1'b0;
`endif

  assign w_clrGo  = (r_state == IDLE) & w_clrReq;
  assign in_ready = (r_state == IDLE) & ~reset & ~w_clrReq;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_stateNxt = r_state;
    w_divNxt   = r_div;
    w_bitNxt   = r_bit;
    w_ldCntNxt = r_ldCnt;
    w_shiftNxt = r_shift;
    w_sclkNxt  = r_sclk;
    w_sdiNxt   = r_sdi;
    w_csNNxt   = r_csN;
    w_ldNNxt   = r_ldN;
    w_clrNNxt  = r_clrN;
    w_doneNxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_clrGo) begin
          w_stateNxt = CLR;
          w_clrNNxt  = 1'b0;
          w_ldCntNxt = '0;
        end else if (w_accept) begin
          w_stateNxt = CS_SETUP;
          w_csNNxt   = 1'b0;
          w_sclkNxt  = 1'b1;
          w_divNxt   = '0;
          w_bitNxt   = '0;
          for (int c = 0; c < NUM_CH; c++) begin
            w_shiftNxt[c] = in_data[c*DATA_W +: DATA_W];
            w_sdiNxt[c]   = in_data[c*DATA_W + DATA_W - 1];
          end
        end
      end
      CS_SETUP: begin
        if (r_div == LAST_DIV) begin
          w_stateNxt = SHIFT;
          w_divNxt   = '0;
          w_sclkNxt  = 1'b0;
        end else begin
          w_divNxt = r_div + DIV_W'(1);
        end
      end
      SHIFT: begin
        // The MSB is already on SDI from CS_SETUP; later bits advance only when a new low phase begins.
        if (r_div != LAST_DIV) begin
          w_divNxt = r_div + DIV_W'(1);
        end else begin
          w_divNxt = '0;
          if (!r_sclk) begin
            w_sclkNxt = 1'b1;
          end else if (r_bit == LAST_BIT) begin
            w_stateNxt = CS_HOLD;
          end else begin
            w_bitNxt  = r_bit + BIT_W'(1);
            w_sclkNxt = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
              w_shiftNxt[c] = r_shift[c] << 1;
              w_sdiNxt[c]   = w_shiftNxt[c][DATA_W-1];
            end
          end
        end
      end
      CS_HOLD: begin
        if (r_div == LAST_DIV) begin
          w_stateNxt = LD;
          w_csNNxt   = 1'b1;
          w_ldNNxt   = 1'b0;
          w_sdiNxt   = '0;
          w_ldCntNxt = '0;
        end else begin
          w_divNxt = r_div + DIV_W'(1);
        end
      end
      LD: begin
        if (r_ldCnt == LAST_LD) begin
          w_stateNxt = IDLE;
          w_ldNNxt   = 1'b1;
          w_doneNxt  = 1'b1;
        end else begin
          w_ldCntNxt = r_ldCnt + LDC_W'(1);
        end
      end
      CLR: begin
        if (r_ldCnt == LAST_LD) begin
          w_stateNxt = IDLE;
          w_clrNNxt  = 1'b1;
          w_doneNxt  = 1'b1;
        end else begin
          w_ldCntNxt = r_ldCnt + LDC_W'(1);
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_ldCnt <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b1;
      r_sdi   <= '0;
      r_csN   <= 1'b1;
      r_ldN   <= 1'b1;
      r_clrN  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_div   <= w_divNxt;
      r_bit   <= w_bitNxt;
      r_ldCnt <= w_ldCntNxt;
      r_shift <= w_shiftNxt;
      r_sclk  <= w_sclkNxt;
      r_sdi   <= w_sdiNxt;
      r_csN   <= w_csNNxt;
      r_ldN   <= w_ldNNxt;
      r_clrN  <= w_clrNNxt;
      r_done  <= w_doneNxt;
    end
  end

`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
  always_ff @(posedge clk) begin
    if (reset) r_clrPend <= 1'b0;
    else       r_clrPend <= w_clrPendNxt;
  end
`endif

  assign done      = r_done;
  assign dac_sclk  = r_sclk;
  assign dac_sdi   = r_sdi;
  assign dac_cs_n  = r_csN;
  assign dac_ld_n  = r_ldN;
  assign dac_clr_n = r_clrN;

endmodule

// File: tb/tb_serial_dac_drv.sv
// Directed bench for serial_dac_drv: a default instance and a 2-channel CLK_DIV=3 instance.
// With SERIAL_DAC_DRV_CLR_CMD_EN defined, the clear-command scenario is also exercised.
module tb_serial_dac_drv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        aValid, aReady, aDone, aSclk, aCsN, aLdN, aClrN;
  logic [11:0] aData;
  logic [0:0]  aSdi;

  logic        bValid, bReady, bDone, bSclk, bCsN, bLdN, bClrN;
  logic [23:0] bData;
  logic [1:0]  bSdi;

`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
  logic aClrReq, bClrReq;
`endif

  int checks   = 0;
  int failures = 0;

  serial_dac_drv dutA (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (aValid),
    .in_data   (aData),
`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
    .clr_req   (aClrReq),
`endif
    .in_ready  (aReady),
    .done      (aDone),
    .dac_sclk  (aSclk),
    .dac_sdi   (aSdi),
    .dac_cs_n  (aCsN),
    .dac_ld_n  (aLdN),
    .dac_clr_n (aClrN)
  );

  serial_dac_drv #(.DATA_W(12), .NUM_CH(2), .CLK_DIV(3), .LD_W(2)) dutB (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bValid),
    .in_data   (bData),
`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
    .clr_req   (bClrReq),
`endif
    .in_ready  (bReady),
    .done      (bDone),
    .dac_sclk  (bSclk),
    .dac_sdi   (bSdi),
    .dac_cs_n  (bCsN),
    .dac_ld_n  (bLdN),
    .dac_clr_n (bClrN)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word to the default instance and records what the pins did for ncyc cycles after acceptance.
  task automatic runA(input logic [11:0] word, input int ncyc, output logic [11:0] cap,
                      output int nRise, output int doneCyc, output int nDone, output int ldLow,
                      output int csRiseCyc, output int ldFirst, output int badSdi);
    logic prevSclk, prevCs;
    logic [0:0] prevSdi;
    cap = '0; nRise = 0; doneCyc = -1; nDone = 0; ldLow = 0;
    csRiseCyc = -1; ldFirst = -1; badSdi = 0;
    aValid = 1'b1;
    aData  = word;
    tick();
    aValid = 1'b0;
    aData  = ~word;
    prevSclk = aSclk; prevCs = aCsN; prevSdi = aSdi;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (!prevSclk && aSclk) begin
        cap = {cap[10:0], aSdi[0]};
        nRise++;
      end
      if (!prevCs && !aCsN && (aSdi !== prevSdi) && !(prevSclk && !aSclk)) badSdi++;
      if (!prevCs && aCsN && csRiseCyc < 0) csRiseCyc = c;
      if (!aLdN) begin
        ldLow++;
        if (ldFirst < 0) ldFirst = c;
      end
      if (aDone) begin
        nDone++;
        if (doneCyc < 0) doneCyc = c;
      end
      prevSclk = aSclk; prevCs = aCsN; prevSdi = aSdi;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    aValid = 1'b0; aData = '0;
    bValid = 1'b0; bData = '0;
`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
    aClrReq = 1'b0; bClrReq = 1'b0;
`endif
    repeat (3) tick();
    checks++;
    if ({aReady, aDone, aSclk, aSdi, aCsN, aLdN, aClrN} !== 7'b0010111) begin
      failures++;
      $display("[TB] FAIL resetPinsA: got %b expected 0010111", {aReady, aDone, aSclk, aSdi, aCsN, aLdN, aClrN});
    end
    checks++;
    if ({bReady, bDone, bSclk, bSdi, bCsN, bLdN, bClrN} !== 8'b00100111) begin
      failures++;
      $display("[TB] FAIL resetPinsB: got %b expected 00100111", {bReady, bDone, bSclk, bSdi, bCsN, bLdN, bClrN});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({aReady, bReady} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL readyAfterReset: got %b expected 11", {aReady, bReady});
    end
    tick();
    checks++;
    if ({aReady, aDone, aSclk, aSdi, aCsN, aLdN, aClrN} !== 7'b1010111) begin
      failures++;
      $display("[TB] FAIL idlePinsA: got %b expected 1010111", {aReady, aDone, aSclk, aSdi, aCsN, aLdN, aClrN});
    end
  endtask

  task automatic test_single_word();
    logic [11:0] cap;
    int nRise, doneCyc, nDone, ldLow, csRise, ldFirst, badSdi;
    runA(12'hA5C, 35, cap, nRise, doneCyc, nDone, ldLow, csRise, ldFirst, badSdi);
    checks++;
    if (cap !== 12'hA5C || nRise != 12) begin
      failures++;
      $display("[TB] FAIL wordA5C: got %h over %0d rises expected a5c over 12", cap, nRise);
    end
    checks++;
    if (doneCyc != 28 || nDone != 1) begin
      failures++;
      $display("[TB] FAIL doneLatency: got cycle %0d count %0d expected cycle 28 count 1", doneCyc, nDone);
    end
    checks++;
    if (ldLow != 2 || csRise != 26 || ldFirst != 26) begin
      failures++;
      $display("[TB] FAIL ldTiming: got ldLow %0d csRise %0d ldFirst %0d expected 2 26 26", ldLow, csRise, ldFirst);
    end
    checks++;
    if (badSdi != 0) begin
      failures++;
      $display("[TB] FAIL sdiStable: got %0d changes outside low-phase start expected 0", badSdi);
    end
  endtask

  task automatic test_two_channel();
    int nRise = 0, badBits = 0, badRun = 0, nLow = 0, lowRun = 0, highRun = 1;
    int done1 = -1, done2 = -1, acc2 = -1, readyAtDone = 0;
    logic prevSclk, dropNext;
    bValid = 1'b1;
    bData  = {12'h000, 12'hFFF};
    tick();
    prevSclk = bSclk;
    dropNext = 1'b0;
    for (int c = 1; c <= 170; c++) begin
      tick();
      if (dropNext) bValid = 1'b0;
      if (!prevSclk && bSclk) begin
        nRise++;
        if (bSdi !== 2'b01) badBits++;
        if (lowRun != 3) badRun++;
        nLow++;
        lowRun = 0;
      end
      if (prevSclk && !bSclk) begin
        if (highRun != 3) badRun++;
        highRun = 0;
      end
      if (!bSclk) lowRun++;
      if (bCsN) highRun = 0;
      else if (bSclk) highRun++;
      if (bDone) begin
        if (done1 < 0) done1 = c;
        else if (done2 < 0) done2 = c;
      end
      if (bValid && bReady && !dropNext) begin
        acc2 = c + 1;
        readyAtDone = bDone;
        dropNext = 1'b1;
      end
      prevSclk = bSclk;
    end
    checks++;
    if (nRise != 24 || badBits != 0) begin
      failures++;
      $display("[TB] FAIL twoChData: got %0d rises %0d bad bits expected 24 rises 0 bad", nRise, badBits);
    end
    checks++;
    if (badRun != 0 || nLow != 24) begin
      failures++;
      $display("[TB] FAIL sclkPhases: got %0d bad phases %0d low phases expected 0 and 24", badRun, nLow);
    end
    checks++;
    if (done1 != 80 || acc2 != 81 || readyAtDone != 1) begin
      failures++;
      $display("[TB] FAIL backToBack: got done %0d accept %0d readyAtDone %0d expected 80 81 1", done1, acc2, readyAtDone);
    end
    checks++;
    if (done2 != 161) begin
      failures++;
      $display("[TB] FAIL secondDone: got %0d expected 161", done2);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [11:0] cap;
    int nRise, doneCyc, nDone, ldLow, csRise, ldFirst, badSdi;
    int ldSeen = 0, doneSeen = 0;
    aValid = 1'b1;
    aData  = 12'hFFF;
    tick();
    aValid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (!aLdN) ldSeen++;
      if (aDone) doneSeen++;
    end
    checks++;
    if ({aCsN, aSclk, aSdi} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL bit6Low: got %b expected 001", {aCsN, aSclk, aSdi});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({aCsN, aSclk, aSdi, aReady} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL midReset: got %b expected 1100", {aCsN, aSclk, aSdi, aReady});
    end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!aLdN) ldSeen++;
      if (aDone) doneSeen++;
    end
    checks++;
    if (ldSeen != 0 || doneSeen != 0) begin
      failures++;
      $display("[TB] FAIL abortQuiet: got ldLow %0d done %0d expected 0 0", ldSeen, doneSeen);
    end
    runA(12'h3C6, 35, cap, nRise, doneCyc, nDone, ldLow, csRise, ldFirst, badSdi);
    checks++;
    if (cap !== 12'h3C6 || doneCyc != 28) begin
      failures++;
      $display("[TB] FAIL afterReset: got %h done %0d expected 3c6 done 28", cap, doneCyc);
    end
  endtask

  task automatic test_busy_valid();
    logic [23:0] cap = '0;
    logic [11:0] expSecond = '0;
    int nRise = 0, nDone = 0, accCyc = -1, doneAtAccept = 0, nAccept = 0;
    logic prevSclk, dropNext;
    aValid = 1'b1;
    aData  = 12'h111;
    tick();
    prevSclk = aSclk;
    dropNext = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (dropNext) aValid = 1'b0;
      if (!prevSclk && aSclk) begin
        cap = {cap[22:0], aSdi[0]};
        nRise++;
      end
      if (aDone) nDone++;
      aData = 12'(c * 859) ^ 12'hA0F;
      if (aValid && aReady) begin
        nAccept++;
        accCyc = c;
        expSecond = aData;
        doneAtAccept = aDone;
        dropNext = 1'b1;
      end
      prevSclk = aSclk;
    end
    checks++;
    if (cap[23:12] !== 12'h111) begin
      failures++;
      $display("[TB] FAIL busyFirst: got %h expected 111", cap[23:12]);
    end
    checks++;
    if (cap[11:0] !== expSecond || nRise != 24) begin
      failures++;
      $display("[TB] FAIL busySecond: got %h over %0d rises expected %h over 24", cap[11:0], nRise, expSecond);
    end
    checks++;
    if (nDone != 2 || nAccept != 1 || accCyc != 28 || doneAtAccept != 1) begin
      failures++;
      $display("[TB] FAIL busyHandshake: got done %0d accepts %0d at %0d doneAtAccept %0d expected 2 1 28 1",
               nDone, nAccept, accCyc, doneAtAccept);
    end
  endtask

`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
  task automatic test_clr_cmd();
    int nDone = 0, done1 = -1, done2 = -1, clrLow = 0, clrFirst = -1, acc = -1;
    logic dropNext = 1'b0;
    aValid = 1'b1;
    aData  = 12'h5A5;
    tick();
    aData = 12'h0F0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (dropNext) aValid = 1'b0;
      aClrReq = (c == 10);
      if (aDone) begin
        nDone++;
        if (done1 < 0) done1 = c;
        else if (done2 < 0) done2 = c;
      end
      if (!aClrN) begin
        clrLow++;
        if (clrFirst < 0) clrFirst = c;
      end
      if (aValid && aReady && !dropNext) begin
        acc = c + 1;
        dropNext = 1'b1;
      end
    end
    aClrReq = 1'b0;
    repeat (30) tick();
    checks++;
    if (done1 != 28 || done2 != 31 || nDone != 2) begin
      failures++;
      $display("[TB] FAIL clrDones: got %0d %0d count %0d expected 28 31 2", done1, done2, nDone);
    end
    checks++;
    if (clrLow != 2 || clrFirst != 29 || acc != 32) begin
      failures++;
      $display("[TB] FAIL clrOrder: got clrLow %0d first %0d accept %0d expected 2 29 32", clrLow, clrFirst, acc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_two_channel();
    test_reset_mid_transfer();
    test_busy_valid();
`ifdef SERIAL_DAC_DRV_CLR_CMD_EN
    test_clr_cmd();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
